move_scan_ctrl: RTL and testbench

//  Move-generation sequencer for the 32-square bitboard engine. Time-shares one diagonal

---
 rtl/move_scan_ctrl_pkg.sv | 53 +++++
 rtl/move_scan_ctrl_if.sv | 27 ++
 rtl/move_scan_ctrl_diag_shift.sv | 24 ++
 rtl/move_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_move_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/move_scan_ctrl_pkg.sv
// Shared types, board geometry and helpers for the move-scan sequencer.
package move_scan_ctrl_pkg;

    localparam int N_SQ   = 32;
    localparam int N_ROWS = N_SQ / 4;

    typedef enum logic [1:0] {
        DIR_UL = 2'd0,
        DIR_UR = 2'd1,
        DIR_DL = 2'd2,
        DIR_DR = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_0,
        PH_1,
        PH_2
    } phase_e;

    // Low bit of the 32-bit slice for direction d inside a 128-bit mask.
    function automatic int unsigned mask_lo(input dir_e d);
        return N_SQ * int'(d);
    endfunction

    // Downward directions are forward for side 1, upward ones for side 0.
    function automatic logic is_forward(input dir_e d, input logic side);
        return ((d == DIR_DL) || (d == DIR_DR)) == side;
    endfunction

    // Neighbour of square i in direction d: bit 5 set means off-board,
    // otherwise bits 4:0 hold the neighbour index.
    function automatic logic [5:0] neighbour(input dir_e d, input int unsigned i);
        int r;
        int c;
        int nr;
        int nc;
        r  = int'(i / 4);
        c  = 2 * int'(i % 4) + (r % 2);
        nr = ((d == DIR_DL) || (d == DIR_DR)) ? r + 1 : r - 1;
        nc = ((d == DIR_UR) || (d == DIR_DR)) ? c + 1 : c - 1;
        if ((nr < 0) || (nr >= N_ROWS) || (nc < 0) || (nc > 7)) begin
            return 6'b10_0000;
        end
        return {1'b0, 5'(nr * 4 + nc / 2)};
    endfunction

endpackage

// File: rtl/move_scan_ctrl_if.sv
// Request/result bundle between the move selector and the scan sequencer.
interface move_scan_if;
    import move_scan_ctrl_pkg::*;

    logic                start;
    logic                side;
    logic [N_SQ-1:0]     own_bb;
    logic [N_SQ-1:0]     opp_bb;
    logic [N_SQ-1:0]     king_bb;
    logic                busy;
    logic                done;
    logic [4*N_SQ-1:0]   move_mask;
    logic [4*N_SQ-1:0]   jump_mask;
    logic                any_move;
    logic                any_jump;

    modport master (
        output start, side, own_bb, opp_bb, king_bb,
        input  busy, done, move_mask, jump_mask, any_move, any_jump
    );

    modport slave (
        input  start, side, own_bb, opp_bb, king_bb,
        output busy, done, move_mask, jump_mask, any_move, any_jump
    );

endinterface

// File: rtl/move_scan_ctrl_diag_shift.sv
// Combinational diagonal shifter: y[i] = x[neighbour(i)], off-board reads 1.
module diag_shift
    import move_scan_ctrl_pkg::*;
(
    input  dir_e            dir,
    input  logic [N_SQ-1:0] x,
    output logic [N_SQ-1:0] y
);

    logic [5:0] nb;

    // Gather each square's neighbour bit; the border fills with 1 (blocked).
    always_comb begin
        y  = '1;
        nb = '0;
        for (int unsigned i = 0; i < N_SQ; i++) begin
            nb = neighbour(dir, i);
            if (!nb[5]) begin
                y[i] = x[nb[4:0]];
            end
        end
    end

endmodule

// File: rtl/move_scan_ctrl.sv
// Move-generation sequencer: time-shares one diagonal shifter over four
// directions to build simple-move and capture source masks.
module move_scan_ctrl
    import move_scan_ctrl_pkg::*;
#(
    parameter int BOARD_W    = 32,
    parameter bit SKIP_EMPTY = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    move_scan_if.slave bus
);

    state_e                 state;
    phase_e                 ph;
    dir_e                   dir;
    logic                   side_q;
    logic [BOARD_W-1:0]     own_q;
    logic [BOARD_W-1:0]     opp_q;
    logic [BOARD_W-1:0]     king_q;
    logic [BOARD_W-1:0]     t1;
    logic [BOARD_W-1:0]     t2;
    logic [BOARD_W-1:0]     shift_in;
    logic [BOARD_W-1:0]     shift_out;
    logic [BOARD_W-1:0]     mover;
    logic [4*BOARD_W-1:0]   move_q;
    logic [4*BOARD_W-1:0]   jump_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   any_move_q;
    logic                   any_jump_q;

    // Shifter operand by phase: occupancy, inverted opponents, then t1.
    always_comb begin
        case (ph)
            PH_0:    shift_in = own_q | opp_q;
            PH_1:    shift_in = ~opp_q;
            default: shift_in = t1;
        endcase
    end

    diag_shift u_shift (
        .dir (dir),
        .x   (shift_in),
        .y   (shift_out)
    );

    // Pieces allowed to move in the current direction.
    always_comb begin
        mover = own_q & (is_forward(dir, side_q) ? {BOARD_W{1'b1}} : king_q);
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.move_mask = move_q;
    assign bus.jump_mask = jump_q;
    assign bus.any_move  = any_move_q;
    assign bus.any_jump  = any_jump_q;

    // Scan FSM: latch boards, walk d=UL..DR through P0..P2, then pulse done.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ph         <= PH_0;
            dir        <= DIR_UL;
            side_q     <= 1'b0;
            own_q      <= '0;
            opp_q      <= '0;
            king_q     <= '0;
            t1         <= '0;
            t2         <= '0;
            move_q     <= '0;
            jump_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            any_move_q <= 1'b0;
            any_jump_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        side_q     <= bus.side;
                        own_q      <= bus.own_bb;
                        opp_q      <= bus.opp_bb;
                        king_q     <= bus.king_bb;
                        move_q     <= '0;
                        jump_q     <= '0;
                        any_move_q <= 1'b0;
                        any_jump_q <= 1'b0;
                        busy_q     <= 1'b1;
                        dir        <= DIR_UL;
                        ph         <= PH_0;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    case (ph)
                        PH_0: begin
                            // An empty mover set leaves the (already cleared)
                            // slices at 0 and moves straight to the next direction.
                            if (SKIP_EMPTY && (mover == '0)) begin
                                if (dir == DIR_DR) begin
                                    state <= ST_DONE;
                                end else begin
                                    dir <= dir_e'(dir + 2'd1);
                                end
                            end else begin
                                t1 <= shift_out;
                                ph <= PH_1;
                            end
                        end
                        PH_1: begin
                            t2 <= ~shift_out;
                            move_q[mask_lo(dir) +: BOARD_W] <= mover & ~t1;
                            ph <= PH_2;
                        end
                        PH_2: begin
                            jump_q[mask_lo(dir) +: BOARD_W] <= mover & t2 & ~shift_out;
                            ph <= PH_0;
                            if (dir == DIR_DR) begin
                                state <= ST_DONE;
                            end else begin
                                dir <= dir_e'(dir + 2'd1);
                            end
                        end
                        default: ph <= PH_0;
                    endcase
                end
                ST_DONE: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    any_move_q <= |move_q;
                    any_jump_q <= |jump_q;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_scan_ctrl.sv
// Self-checking bench for move_scan_ctrl: directed cases plus random boards
// compared against a square-by-square reference of the capture/move rules.
module tb_move_scan_ctrl;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        side;
    logic [31:0] own;
    logic [31:0] opp;
    logic [31:0] king;

    int checks   = 0;
    int failures = 0;

    move_scan_if bus0 ();
    move_scan_if bus1 ();

    assign bus0.start   = start;
    assign bus0.side    = side;
    assign bus0.own_bb  = own;
    assign bus0.opp_bb  = opp;
    assign bus0.king_bb = king;
    assign bus1.start   = start;
    assign bus1.side    = side;
    assign bus1.own_bb  = own;
    assign bus1.opp_bb  = opp;
    assign bus1.king_bb = king;

    move_scan_ctrl #(.BOARD_W(32), .SKIP_EMPTY(1'b0)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    move_scan_ctrl #(.BOARD_W(32), .SKIP_EMPTY(1'b1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Dark-square index at (row, col), or -1 when off-board / light square.
    function automatic int sq(input int r, input int c);
        if (r < 0 || r > 7 || c < 0 || c > 7 || ((r ^ c) & 1) != 0) return -1;
        return r * 4 + c / 2;
    endfunction

    function automatic void ref_scan(input bit s, input logic [31:0] o, input logic [31:0] p,
                                     input logic [31:0] k, output logic [127:0] mv,
                                     output logic [127:0] jp);
        mv = '0;
        jp = '0;
        for (int d = 0; d < 4; d++) begin
            int dr;
            int dc;
            int r;
            int c;
            int n;
            int l;
            bit fwd;
            dr  = (d >= 2) ? 1 : -1;
            dc  = (d % 2 == 1) ? 1 : -1;
            fwd = (s == 1'b0) ? (d < 2) : (d >= 2);
            for (int i = 0; i < 32; i++) begin
                r = i / 4;
                c = 2 * (i % 4) + (r % 2);
                n = sq(r + dr, c + dc);
                l = sq(r + 2 * dr, c + 2 * dc);
                if (o[i] && (fwd || k[i])) begin
                    if (n >= 0 && !o[n] && !p[n]) mv[32 * d + i] = 1'b1;
                    if (n >= 0 && p[n] && l >= 0 && !o[l] && !p[l]) jp[32 * d + i] = 1'b1;
                end
            end
        end
    endfunction

    // Expected scan length when empty directions are skipped.
    function automatic int ref_skip_lat(input bit s, input logic [31:0] o, input logic [31:0] k);
        int lat;
        lat = 1;
        for (int d = 0; d < 4; d++) begin
            bit fwd;
            fwd = (s == 1'b0) ? (d < 2) : (d >= 2);
            lat += ((o & (fwd ? 32'hFFFF_FFFF : k)) == 32'd0) ? 1 : 3;
        end
        return lat;
    endfunction

    // Pulse start for one edge; return cycles from that edge to each done.
    task automatic run_scan(input string tag, output int lat0, output int lat1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, ".busy0"}, bus0.busy, 1'b1);
        check({tag, ".clr0"}, {bus0.move_mask | bus0.jump_mask}, '0);
        check({tag, ".clr1"}, {bus1.move_mask | bus1.jump_mask}, '0);
        lat0 = -1;
        lat1 = -1;
        for (int n = 1; n <= 40 && (lat0 < 0 || lat1 < 0); n++) begin
            @(posedge clock); #1;
            if (lat0 < 0 && bus0.done) lat0 = n;
            if (lat1 < 0 && bus1.done) lat1 = n;
        end
    endtask

    task automatic check_scan(input string tag, input bit s, input logic [31:0] o,
                              input logic [31:0] p, input logic [31:0] k,
                              input int lat0, input int lat1, input bit with_dut1);
        logic [127:0] mv;
        logic [127:0] jp;
        ref_scan(s, o, p, k, mv, jp);
        check({tag, ".lat0"}, lat0, 13);
        check({tag, ".mv0"}, bus0.move_mask, mv);
        check({tag, ".jp0"}, bus0.jump_mask, jp);
        check({tag, ".anym0"}, bus0.any_move, |mv);
        check({tag, ".anyj0"}, bus0.any_jump, |jp);
        if (with_dut1) begin
            check({tag, ".lat1"}, lat1, ref_skip_lat(s, o, k));
            check({tag, ".mv1"}, bus1.move_mask, mv);
            check({tag, ".jp1"}, bus1.jump_mask, jp);
            check({tag, ".anym1"}, bus1.any_move, |mv);
            check({tag, ".anyj1"}, bus1.any_jump, |jp);
        end
    endtask

    initial begin
        int          l0;
        int          l1;
        bit          s_l;
        logic [31:0] o_l;
        logic [31:0] p_l;
        logic [31:0] k_l;

        reset_n = 1'b0;
        start   = 1'b0;
        side    = 1'b0;
        own     = '0;
        opp     = '0;
        king    = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst.busy", {bus0.busy, bus1.busy}, 2'b00);
        check("rst.done", {bus0.done, bus1.done}, 2'b00);
        check("rst.any", {bus0.any_move, bus0.any_jump, bus1.any_move, bus1.any_jump}, 4'b0);
        check("rst.mask0", {bus0.move_mask, bus0.jump_mask} != '0, 1'b0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 1: lone man on 9 moving up
        side = 1'b0; own = 32'h1 << 9; opp = '0; king = '0;
        run_scan("t1", l0, l1);
        check_scan("t1", side, own, opp, king, l0, l1, 1'b1);
        check("t1.ul9", bus0.move_mask[9], 1'b1);
        check("t1.ur9", bus0.move_mask[32 + 9], 1'b1);
        check("t1.down", bus0.move_mask[127:64], '0);
        @(posedge clock); #1;
        check("t1.done_pulse", bus0.done, 1'b0);
        check("t1.busy_after", bus0.busy, 1'b0);

        // 2: capture up-right over 5 landing on 2
        own = 32'h1 << 9; opp = 32'h1 << 5;
        run_scan("t2", l0, l1);
        check_scan("t2", side, own, opp, king, l0, l1, 1'b1);
        check("t2.ur_mv", bus0.move_mask[32 + 9], 1'b0);
        check("t2.ul_mv", bus0.move_mask[9], 1'b1);
        check("t2.ur_jp", bus0.jump_mask[32 + 9], 1'b1);
        check("t2.anyj", bus0.any_jump, 1'b1);

        // 3: capture blocked by the left border
        own = 32'h1 << 12; opp = 32'h1 << 8;
        run_scan("t3", l0, l1);
        check_scan("t3", side, own, opp, king, l0, l1, 1'b1);
        check("t3.ul_mv", bus0.move_mask[12], 1'b0);
        check("t3.ul_jp", bus0.jump_mask[12], 1'b0);
        check("t3.ur_mv", bus0.move_mask[32 + 12], 1'b1);

        // 4: king on the top edge
        own = 32'h1 << 3; opp = '0; king = 32'h1 << 3;
        run_scan("t4", l0, l1);
        check_scan("t4", side, own, opp, king, l0, l1, 1'b1);
        check("t4.up", {bus0.move_mask[3], bus0.move_mask[32 + 3]}, 2'b00);
        check("t4.dl", bus0.move_mask[64 + 3], 1'b1);
        check("t4.dr", bus0.move_mask[96 + 3], 1'b1);

        // 5: reset in the middle of a scan
        own = 32'h0000_0F00; opp = 32'h0000_00F0; king = '0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("t5.busy", {bus0.busy, bus1.busy}, 2'b00);
        check("t5.masks", {bus0.move_mask, bus0.jump_mask} != '0, 1'b0);
        check("t5.done", {bus0.done, bus1.done}, 2'b00);
        reset_n = 1'b1;
        own = 32'h1 << 9; opp = 32'h1 << 5; king = '0;
        run_scan("t5r", l0, l1);
        check_scan("t5r", side, own, opp, king, l0, l1, 1'b1);

        // 6: start held, inputs churned while busy; only the first boards count
        side = 1'b1; own = 32'h0F00_0000; opp = 32'h00F0_0000; king = 32'h0100_0000;
        s_l = side; o_l = own; p_l = opp; k_l = king;
        start = 1'b1;
        @(posedge clock); #1;
        l0 = -1;
        for (int n = 1; n <= 40 && l0 < 0; n++) begin
            side = 1'($urandom);
            own  = $urandom;
            opp  = $urandom & ~own;
            king = $urandom;
            @(posedge clock); #1;
            if (bus0.done) l0 = n;
        end
        start = 1'b0;
        check_scan("t6", s_l, o_l, p_l, k_l, l0, 0, 1'b0);
        @(posedge clock); #1;
        check("t6.single", bus0.busy, 1'b0);
        l1 = -1;
        for (int n = 0; n <= 40 && l1 < 0; n++) begin
            if (!bus1.busy) l1 = n;
            else begin
                @(posedge clock); #1;
            end
        end
        check("t6.dut1_idle", l1 >= 0, 1'b1);

        // empty side to move: full scan, nothing found; skipping DUT finishes in 5
        side = 1'b0; own = '0; opp = 32'h00FF_0000; king = '0;
        run_scan("t7", l0, l1);
        check_scan("t7", side, own, opp, king, l0, l1, 1'b1);
        check("t7.lat1", l1, 5);

        // random boards, issued back-to-back
        for (int it = 0; it < 24; it++) begin
            side = 1'($urandom);
            own  = $urandom;
            if (it % 3 == 0) own = own & $urandom & $urandom;
            opp  = $urandom & ~own;
            king = $urandom & (own | opp);
            run_scan("rnd", l0, l1);
            check_scan($sformatf("rnd%0d", it), side, own, opp, king, l0, l1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
